// File: rtl/axi_4_lite_regbank_pkg.sv
// axi_4_lite_regbank_pkg: response codes, FSM state types and address helper shared by the register bank
package axi_4_lite_regbank_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic int addr_lsb(input int dw);
    return (dw == 64) ? 3 : 2;
  endfunction
endpackage

// File: rtl/axi_4_lite_strb_merge.sv
// axi_4_lite_strb_merge: per-byte select between the old register value and new write data
module axi_4_lite_strb_merge #(
  parameter int C_DATA_WIDTH = 32
) (
  input  logic [C_DATA_WIDTH-1:0]   i_old,
  input  logic [C_DATA_WIDTH-1:0]   i_new,
  input  logic [C_DATA_WIDTH/8-1:0] i_strb,
  output logic [C_DATA_WIDTH-1:0]   o_merged
);
  for (genvar b = 0; b < C_DATA_WIDTH / 8; b++) begin : g_byte
    assign o_merged[8*b +: 8] = i_strb[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
  end
endmodule

// File: rtl/axi_4_lite_regbank.sv
// axi_4_lite_regbank: AXI4-Lite slave register bank with per-register RO/RW mode and user-side taps
module axi_4_lite_regbank
  import axi_4_lite_regbank_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH   = 32,
  parameter int C_AXI_ADDR_WIDTH   = 8,
  parameter int C_REGISTERS_NUMBER = 16,
  parameter logic [C_REGISTERS_NUMBER-1:0] C_RO_MASK = '0
) (
  input  logic                                         S_AXI_ACLK,
  input  logic                                         S_AXI_ARESET,
  input  logic                                         S_AXI_AWVALID,
  output logic                                         S_AXI_AWREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic [2:0]                                   S_AXI_AWPROT,
  input  logic                                         S_AXI_WVALID,
  output logic                                         S_AXI_WREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
  output logic                                         S_AXI_BVALID,
  input  logic                                         S_AXI_BREADY,
  output logic [1:0]                                   S_AXI_BRESP,
  input  logic                                         S_AXI_ARVALID,
  output logic                                         S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic [2:0]                                   S_AXI_ARPROT,
  output logic                                         S_AXI_RVALID,
  input  logic                                         S_AXI_RREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                                   S_AXI_RRESP,
  output logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] usr_reg_q,
  input  logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] usr_ro_d,
  output logic [C_REGISTERS_NUMBER-1:0]                usr_wr_pulse
);
  localparam int DW  = C_AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int AW  = C_AXI_ADDR_WIDTH;
  localparam int N   = C_REGISTERS_NUMBER;
  localparam int LSB = addr_lsb(DW);
  localparam int IW  = AW - LSB;

  w_state_e          r_wstate, w_wnext;
  r_state_e          r_rstate, w_rnext;
  logic [AW-1:0]     r_awaddr;
  logic [DW-1:0]     r_wdata;
  logic [SW-1:0]     r_wstrb;
  logic [1:0]        r_bresp, r_rresp;
  logic [DW-1:0]     r_rdata;
  logic [N-1:0]      r_pulse;
  logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [AW-1:0]     w_cmt_addr;
  logic [DW-1:0]     w_cmt_data;
  logic [SW-1:0]     w_cmt_strb;
  logic [IW-1:0]     w_wr_idx, w_rd_idx;
  logic [N-1:0]      w_wr_hit, w_rd_hit;
  logic [N*DW-1:0]   w_reg_q;
  logic [DW-1:0]     w_rd_data;
  logic              w_unused;

  assign S_AXI_AWREADY = !S_AXI_ARESET && (r_wstate == W_IDLE || r_wstate == W_HAVE_DATA);
  assign S_AXI_WREADY  = !S_AXI_ARESET && (r_wstate == W_IDLE || r_wstate == W_HAVE_ADDR);
  assign S_AXI_ARREADY = !S_AXI_ARESET && r_rstate == R_IDLE;
  assign S_AXI_BVALID  = r_wstate == W_RESP;
  assign S_AXI_RVALID  = r_rstate == R_DATA;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign usr_reg_q     = w_reg_q;
  assign usr_wr_pulse  = r_pulse;

  assign w_aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  // A write commits once both halves are in hand, whether held from earlier or arriving now
  assign w_commit   = (w_aw_hs || r_wstate == W_HAVE_ADDR) && (w_w_hs || r_wstate == W_HAVE_DATA);
  assign w_cmt_addr = r_wstate == W_HAVE_ADDR ? r_awaddr : S_AXI_AWADDR;
  assign w_cmt_data = r_wstate == W_HAVE_DATA ? r_wdata : S_AXI_WDATA;
  assign w_cmt_strb = r_wstate == W_HAVE_DATA ? r_wstrb : S_AXI_WSTRB;
  assign w_wr_idx   = w_cmt_addr[AW-1:LSB];
  assign w_rd_idx   = S_AXI_ARADDR[AW-1:LSB];
  assign w_unused   = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_cmt_addr[LSB-1:0], S_AXI_ARADDR[LSB-1:0], usr_ro_d};

  // Write FSM next state
  always_comb begin
    w_wnext = w_commit ? W_RESP : (r_wstate == W_RESP && S_AXI_BREADY) ? W_IDLE :
              w_aw_hs ? W_HAVE_ADDR : w_w_hs ? W_HAVE_DATA : r_wstate;
  end

  // Read FSM next state
  always_comb begin
    w_rnext = w_ar_hs ? R_DATA : (r_rstate == R_DATA && S_AXI_RREADY) ? R_IDLE : r_rstate;
  end

  // State registers for both channels
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  // Hold whichever write half arrives first
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
    if (w_w_hs) begin
      r_wdata <= S_AXI_WDATA;
      r_wstrb <= S_AXI_WSTRB;
    end
  end

  // Write response and user pulse, decided at the commit edge
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_bresp <= RESP_OKAY;
      r_pulse <= '0;
    end else begin
      r_pulse <= w_commit ? (w_wr_hit & ~C_RO_MASK) : '0;
      if (w_commit)
        r_bresp <= !(|w_wr_hit) ? RESP_DECERR : |(w_wr_hit & C_RO_MASK) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read source select; RO registers come straight from user logic
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N; i++)
      if (w_rd_hit[i]) w_rd_data = C_RO_MASK[i] ? usr_ro_d[i*DW +: DW] : w_reg_q[i*DW +: DW];
  end

  // Read data capture at the AR handshake
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_data;
      r_rresp <= |w_rd_hit ? RESP_OKAY : RESP_DECERR;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_reg
    assign w_wr_hit[i] = w_wr_idx == IW'(i);
    assign w_rd_hit[i] = w_rd_idx == IW'(i);
    if (C_RO_MASK[i]) begin : g_ro
      assign w_reg_q[i*DW +: DW] = '0;
    end else begin : g_rw
      logic [DW-1:0] r_reg, w_merged;
      axi_4_lite_strb_merge #(.C_DATA_WIDTH(DW)) u_merge (
        .i_old(r_reg), .i_new(w_cmt_data), .i_strb(w_cmt_strb), .o_merged(w_merged)
      );
      // RW register storage, byte-merged on commit
      always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_reg <= '0;
        else if (w_commit && w_wr_hit[i]) r_reg <= w_merged;
      end
      assign w_reg_q[i*DW +: DW] = r_reg;
    end
  end
endmodule
